// File: rtl/rr_bus_arbiter8.sv
// ============================================================================
// Module   : rr_bus_arbiter8
// Summary  : Round-robin arbiter that shares one DATA_W result bus among 8
//            requesters, with a valid/ready handshake toward the consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_bus_arbiter8 #(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            req_i,
    input  logic [8*DATA_W-1:0]   data_in_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [2:0]            sel_o,
    output logic [7:0]            grant_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W:0] c_MAX_HOLD = (CNT_W + 1)'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic [2:0]         ptr_q;
    logic [7:0]         grant_q;
    logic               busy_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic               w_found;
    logic [2:0]         w_pick;
    logic [2:0]         w_idx;
    logic               w_transfer;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_last;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_idx   = '0;
        for (int k = 7; k >= 0; k--) begin
            w_idx = ptr_q + 3'(k);
            if (req_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign out_valid_o = busy_q & req_i[sel_q];
    assign out_data_o  = data_in_i[sel_q*DATA_W +: DATA_W];
    assign sel_o       = sel_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

    assign w_transfer  = out_valid_o & out_ready_i;
    assign w_cnt_inc   = {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);
    assign w_last      = (w_cnt_inc == c_MAX_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        state_q    <= S_GRANT;
                        sel_q      <= w_pick;
                        grant_q    <= 8'b1 << w_pick;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                S_GRANT: begin
                    // A withdrawn request releases without counting a beat.
                    if (!req_i[sel_q] || (w_transfer && w_last)) begin
                        state_q    <= S_IDLE;
                        ptr_q      <= sel_q + 3'd1;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        beat_cnt_q <= '0;
                    end else if (w_transfer) begin
                        beat_cnt_q <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
